// File: rtl/sdram_line_responder.sv
// sdram_line_responder
// Responder side of the VGA line-burst handshake. Accepts a line request,
// issues one BURST_LEN-word read to the SDRAM controller and streams the
// returned words out with a closing done pulse. A single-word general-purpose
// port shares the controller and is served whenever no line burst is pending.
module sdram_line_responder #(
  parameter int unsigned BURST_LEN = 128,  // words per line burst, 1..255
  parameter int unsigned ADDR_W    = 24
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  // line-burst port
  input  logic              line_req,
  input  logic [ADDR_W-1:0] line_addr,
  output logic              line_grant,
  output logic [15:0]       line_data,
  output logic              line_valid,
  output logic              line_done,
  // general-purpose single-word port
  input  logic              gp_req,
  input  logic              gp_we,
  input  logic [ADDR_W-1:0] gp_addr,
  input  logic [15:0]       gp_wdata,
  output logic              gp_ack,
  output logic [15:0]       gp_rdata,
  // SDRAM controller command / read-return port
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic              mem_cmd_we,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  output logic [7:0]        mem_cmd_len,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_rvalid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_L_CMD,
    S_L_DATA,
    S_L_DONE,
    S_G_CMD,
    S_G_WAIT
  } state_e;

  localparam logic [7:0] BurstLenW = 8'(BURST_LEN);

  state_e            state_q;
  logic [7:0]        cnt_q;
  logic              armed_q;

  logic              line_grant_q;
  logic [15:0]       line_data_q;
  logic              line_valid_q;
  logic              line_done_q;
  logic              gp_ack_q;
  logic [15:0]       gp_rdata_q;
  logic              mem_cmd_valid_q;
  logic              mem_cmd_we_q;
  logic [ADDR_W-1:0] mem_cmd_addr_q;
  logic [7:0]        mem_cmd_len_q;
  logic [15:0]       mem_wdata_q;

  logic [7:0]        cnt_d;

  // Word count after accepting the current return beat; BURST_LEN <= 255 so
  // this never wraps before the terminal compare fires.
  assign cnt_d = cnt_q + 8'd1;

  // Handshake FSM with all outputs registered. The command registers double
  // as the latched request fields, so nothing else needs storing.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    // NOTE: every state element, including the data registers, is cleared on
    // reset so an aborted burst leaves no stale word or strobe on the outputs.
    if (!rst_n) begin
      state_q         <= S_IDLE;
      cnt_q           <= 8'd0;
      armed_q         <= 1'b1;
      line_grant_q    <= 1'b0;
      line_data_q     <= 16'd0;
      line_valid_q    <= 1'b0;
      line_done_q     <= 1'b0;
      gp_ack_q        <= 1'b0;
      gp_rdata_q      <= 16'd0;
      mem_cmd_valid_q <= 1'b0;
      mem_cmd_we_q    <= 1'b0;
      mem_cmd_addr_q  <= '0;
      mem_cmd_len_q   <= 8'd0;
      mem_wdata_q     <= 16'd0;
    end else begin
      // NOTE: non-blocking assignments throughout; the pulse defaults below
      // are overridden by later assignments in the same cycle, never raced.
      line_grant_q <= 1'b0;
      line_valid_q <= 1'b0;
      line_done_q  <= 1'b0;
      gp_ack_q     <= 1'b0;

      // A low line_req re-arms the line port; the finished burst disarms it
      // so a request still held from that burst cannot be granted again.
      if (!line_req) begin
        armed_q <= 1'b1;
      end else if (state_q == S_L_DONE) begin
        armed_q <= 1'b0;
      end

      unique case (state_q)
        S_IDLE: begin
          if (line_req && armed_q) begin
            line_grant_q    <= 1'b1;
            mem_cmd_valid_q <= 1'b1;
            mem_cmd_we_q    <= 1'b0;
            mem_cmd_addr_q  <= line_addr;
            mem_cmd_len_q   <= BurstLenW;
            state_q         <= S_L_CMD;
          end else if (gp_req) begin
            mem_cmd_valid_q <= 1'b1;
            mem_cmd_we_q    <= gp_we;
            mem_cmd_addr_q  <= gp_addr;
            mem_cmd_len_q   <= 8'd1;
            mem_wdata_q     <= gp_wdata;
            state_q         <= S_G_CMD;
          end
        end

        S_L_CMD: begin
          if (mem_cmd_ready) begin
            mem_cmd_valid_q <= 1'b0;
            state_q         <= S_L_DATA;
          end
        end

        S_L_DATA: begin
          if (mem_rvalid) begin
            line_data_q  <= mem_rdata;
            line_valid_q <= 1'b1;
            cnt_q        <= cnt_d;
            if (cnt_d == BurstLenW) begin
              state_q <= S_L_DONE;
            end
          end
        end

        S_L_DONE: begin
          line_done_q <= 1'b1;
          cnt_q       <= 8'd0;
          state_q     <= S_IDLE;
        end

        S_G_CMD: begin
          if (mem_cmd_ready) begin
            mem_cmd_valid_q <= 1'b0;
            if (mem_cmd_we_q) begin
              gp_ack_q <= 1'b1;
              state_q  <= S_IDLE;
            end else begin
              state_q <= S_G_WAIT;
            end
          end
        end

        S_G_WAIT: begin
          if (mem_rvalid) begin
            gp_rdata_q <= mem_rdata;
            gp_ack_q   <= 1'b1;
            state_q    <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign line_grant    = line_grant_q;
  assign line_data     = line_data_q;
  assign line_valid    = line_valid_q;
  assign line_done     = line_done_q;
  assign gp_ack        = gp_ack_q;
  assign gp_rdata      = gp_rdata_q;
  assign mem_cmd_valid = mem_cmd_valid_q;
  assign mem_cmd_we    = mem_cmd_we_q;
  assign mem_cmd_addr  = mem_cmd_addr_q;
  assign mem_cmd_len   = mem_cmd_len_q;
  assign mem_wdata     = mem_wdata_q;

endmodule

// File: doc/sdram_line_responder.md
# sdram_line_responder

Responder end of the SDRAM line-burst handshake used by the VGA line-fill FSM. It runs in the `clk_sys` (100 MHz) domain. It accepts `line_req`/`line_addr`, answers with a `line_grant` pulse, and issues one burst read to the SDRAM controller command port. It streams `BURST_LEN` words back on `line_data`/`line_valid` and closes each burst with a `line_done` pulse. It also arbitrates a single-word general-purpose (GP) port for framebuffer writes and CPU reads; the line port has priority.

## Interface
- `BURST_LEN`, 128: words per line burst; legal range 1–255.
- `ADDR_W`, 24: word-address width.
- `clk_sys`  in  1  system clock, 100 MHz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `line_req`  in  1  line-burst request; held high until `line_grant` is seen.
- `line_addr`  in  ADDR_W  burst start word address; stable while `line_req` is high.
- `line_grant`  out  1  one-cycle grant pulse.
- `line_data`  out  16  burst data word.
- `line_valid`  out  1  `line_data` is valid.
- `line_done`  out  1  one-cycle burst-complete pulse.
- `gp_req`  in  1  GP request; held high until `gp_ack`.
- `gp_we`  in  1  1 = write, 0 = read.
- `gp_addr`  in  ADDR_W  GP word address.
- `gp_wdata`  in  16  GP write data.
- `gp_ack`  out  1  one-cycle completion pulse.
- `gp_rdata`  out  16  read data, valid while `gp_ack` is high.
- `mem_cmd_valid`  out  1  command valid to the SDRAM controller.
- `mem_cmd_ready`  in  1  controller accepts the command.
- `mem_cmd_we`  out  1  write command.
- `mem_cmd_addr`  out  ADDR_W  command address.
- `mem_cmd_len`  out  8  words in the command.
- `mem_wdata`  out  16  write data.
- `mem_rdata`  in  16  read return data, in order.
- `mem_rvalid`  in  1  `mem_rdata` is valid.

## Operation
- States: IDLE, L_CMD, L_DATA, L_DONE, G_CMD, G_WAIT.
- **Reset.** All outputs are 0, the state is IDLE, the word counter is 0, and the `armed` flag is 1.
- **IDLE arbitration.**
  - If `line_req` and `armed` are both high: latch `line_addr`, pulse `line_grant` on the next cycle, and go to L_CMD.
  - Otherwise, if `gp_req` is high: latch `gp_addr`, `gp_we` and `gp_wdata`, and go to G_CMD.
  - When both ports request in the same cycle, the line port wins. A GP transaction in progress is never preempted.
- **L_CMD.**
  - Drive `mem_cmd_valid=1`, `mem_cmd_we=0`, `mem_cmd_addr` = the latched address, `mem_cmd_len=BURST_LEN`.
  - On `mem_cmd_ready`, drop `mem_cmd_valid` and go to L_DATA.
- **L_DATA.**
  - Each `mem_rvalid` registers `mem_rdata` onto `line_data` with `line_valid=1` and increments the counter.
  - When the counter reaches `BURST_LEN`, go to L_DONE.
- **L_DONE.** Pulse `line_done` for one cycle, clear `armed`, clear the counter, and go to IDLE.
- **Re-arm rule.** `armed` is set in any cycle where `line_req` is sampled low.
  - This prevents a second grant while the initiator still holds `line_req` from the finished burst.
  - The initiator drops `line_req` for at least one cycle between consecutive blocks.
- **G_CMD.**
  - Drive the command with `mem_cmd_len=1` and `mem_wdata` = the latched data.
  - On `mem_cmd_ready`: for a write, pulse `gp_ack` and go to IDLE; for a read, go to G_WAIT.
- **G_WAIT.** On `mem_rvalid`, set `gp_rdata=mem_rdata`, pulse `gp_ack`, and go to IDLE.
- **Stray data.** `mem_rvalid` in IDLE, L_CMD, L_DONE or G_CMD is ignored and dropped.
- **Counter.** The counter is 8 bits and compares equal to `BURST_LEN`; it never wraps inside a burst.

## Timing
- **Grant latency.** `line_req` sampled high in IDLE (with `armed`=1) at edge N gives `line_grant`=1 in cycle N+1 and `mem_cmd_valid`=1 in cycle N+1.
- **Data latency.** `line_valid` follows `mem_rvalid` by exactly 1 cycle, with matching data.
- **Done timing.** `line_done` is asserted in the cycle after the last `line_valid`, never coincident with it.
- **Back-to-back data.** Gaps in `mem_rvalid` pass straight through to `line_valid`.
- **Command hold.** `mem_cmd_valid` is held and the command fields are stable until `mem_cmd_ready` is sampled high.
- **GP acknowledge.** A write `gp_ack` comes 1 cycle after acceptance. A read `gp_ack` comes 1 cycle after `mem_rvalid`.
- **Reset mid-burst.** Outputs clear immediately (asynchronously). No `line_done` is issued for the aborted burst. `armed`=1 after release.
- **Minimum turnaround.** From one `line_done` to the next `line_grant` takes at least 2 cycles: one cycle with `line_req` sampled low, then one sampled high.

## Test plan
- **Single burst.**
  - Stimulus: `line_req` with `line_addr`=0x000400; controller accepts immediately and returns 128 words 0..127 back-to-back.
  - Required: one `line_grant` pulse; `mem_cmd_addr`=0x000400, `mem_cmd_len`=128; `line_valid` high for exactly 128 cycles with data 0..127; a single `line_done` in the cycle after the last word.
- **Initiator-style 9-block line.**
  - Stimulus: `line_req` drops for 1 cycle after each `line_done`; addresses 0x000800 + k·0x80 for k=0..8.
  - Required: 9 grants; 1152 valid words; no extra grant while `line_req` is still high after `line_done`.
- **Priority.**
  - Stimulus: `gp_req` (write 0xBEEF @0x10) and `line_req` raised in the same cycle.
  - Required: the line burst completes first; the GP write command is issued after `line_done`; `gp_ack` then pulses once.
- **GP read with controller stall.**
  - Stimulus: `mem_cmd_ready` held low for 5 cycles; `mem_rdata`=0x1234 returned 3 cycles after acceptance.
  - Required: the command stays stable throughout the stall; `gp_ack`=1 with `gp_rdata`=0x1234 one cycle after `mem_rvalid`.
- **Gapped data and stray valid.**
  - Stimulus: `mem_rvalid` toggled every other cycle during a burst; one stray `mem_rvalid` injected in IDLE.
  - Required: 128 words are delivered in order; the stray word is dropped with no `line_valid`.
- **Reset mid-burst.**
  - Stimulus: `rst_n` asserted after word 40.
  - Required: all outputs 0 immediately; no `line_done`; a new `line_req` after reset is granted normally.
